ahb_input_hold_stage: RTL and testbench
=======================================

AHB_INPUT_HOLD_STAGE -- requirements
Module: ahb_input_hold_stage

Interface
REQ-001 SHALL have ports: HCLK in 1, AHB system clock; all sequential logic on its rising edge.
REQ-002 SHALL have port: HRESET in 1, asynchronous active-high reset.
REQ-003 SHALL have master-side address-phase inputs: HSELS in 1, HADDRS in 32, HTRANSS in 2, HWRITES in 1, HSIZES in 3, HBURSTS in 3, HPROTS in 4, HMASTERS in 4, HMASTLOCKS in 1, HREADYS in 1.
REQ-004 SHALL have master-side response outputs: HREADYOUTS out 1, transfer done; HRESPS out 1, 0=OKAY, 1=ERROR.
REQ-005 SHALL have output-stage feedback inputs: active_ip in 1, the output stage has granted this port this cycle; readyout_ip in 1, routed slave HREADYOUT; resp_ip in 1, routed slave HRESP.
REQ-006 SHALL have outputs to the output stage: sel_ip 1, addr_ip 32, trans_ip 2, write_ip 1, size_ip 3, burst_ip 3, prot_ip 4, master_ip 4, mastlock_ip 1, held_tran_ip 1 (a transfer is pending or live).

Function
REQ-007 SHALL define a valid transfer as HSELS & HTRANSS[1] & HREADYS.
REQ-008 SHALL register all address/control inputs into hold registers whenever HREADYS=1.
REQ-009 SHALL keep a 3-state FSM: IDLE (nothing pending, no data phase), HELD (address captured, not yet granted), DATA (granted, waiting for slave completion).
REQ-010 IDLE->DATA when a valid transfer occurs and active_ip=1 in the same cycle; IDLE->HELD when a valid transfer occurs and active_ip=0.
REQ-011 HELD->DATA when active_ip=1 and readyout_ip=1; otherwise remain HELD.
REQ-012 DATA->IDLE when readyout_ip=1 and no new valid transfer; DATA->DATA or DATA->HELD on a new valid transfer, per REQ-010 rules.
REQ-013 SHALL drive address/control outputs from hold registers in HELD, else directly from HS* inputs (zero-latency pass-through).
REQ-014 SHALL drive held_tran_ip = 1 in HELD, or when a valid transfer is presented; else 0.
REQ-015 SHALL, in HELD, force trans_ip to NONSEQ when the held HTRANS is SEQ, and force burst_ip to INCR when the held burst is fixed-length (burst broken by arbitration).
REQ-016 SHALL drive HREADYOUTS=0 in HELD; HREADYOUTS=readyout_ip in DATA; HREADYOUTS=1 in IDLE.
REQ-017 SHALL drive HRESPS=resp_ip in DATA, else 0.
REQ-018 SHALL ignore IDLE/BUSY HTRANSS for FSM state changes; BUSY passes through to trans_ip unchanged when not HELD.
REQ-019 SHALL give a held transfer priority over any new master input: no second capture while HELD, since HREADYOUTS=0 there.

Reset
REQ-020 On HRESET=1, SHALL enter IDLE and clear hold registers to 0 within the same cycle, asynchronously.
REQ-021 Reset outputs SHALL be: HREADYOUTS=1, HRESPS=0, held_tran_ip=0, trans_ip=IDLE (2'b00), all other outputs equal to the live inputs.
REQ-022 Reset asserted mid-HELD or mid-DATA SHALL discard the pending transfer with no further effect.

Configuration
REQ-023 Macro AHB_HOLD_ERR_CANCEL_EN, when defined: on resp_ip=1 with readyout_ip=0 in DATA (first ERROR cycle), a transfer captured in that cycle SHALL be discarded, the FSM SHALL return to IDLE after the second ERROR cycle, and trans_ip SHALL be IDLE meanwhile.
REQ-024 When AHB_HOLD_ERR_CANCEL_EN is undefined, ERROR responses SHALL pass through with no change to held transfers.

Structure
REQ-025 A shared package SHALL hold: HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HBURST encodings, and the FSM state type.
REQ-026 Single flat module; no sub-module.

Verification
REQ-027 Valid NONSEQ write to 0x2000_0000 with active_ip=1 -> addr_ip=0x2000_0000 the same cycle, FSM=DATA, HREADYOUTS follows readyout_ip.
REQ-028 Valid NONSEQ read to 0x4000_0010 with active_ip=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, addr_ip held at 0x4000_0010, held_tran_ip=1; active_ip=1 -> DATA next cycle.
REQ-029 INCR4 burst whose SEQ beat at 0x1004 is held -> trans_ip=2'b10 and burst_ip=3'b001 while HELD.
REQ-030 With AHB_HOLD_ERR_CANCEL_EN: 2-cycle ERROR (resp_ip=1, readyout_ip 0 then 1) plus a new transfer in cycle 1 -> HRESPS=1 for both cycles, trans_ip=IDLE, FSM=IDLE afterwards; without the macro the transfer is forwarded.
REQ-031 HRESET pulsed while HELD -> HREADYOUTS=1 and held_tran_ip=0 immediately; no transfer reaches the output stage after release.

Source files
------------

// File: rtl/ahb_input_hold_stage_pkg.sv
// Shared encodings and FSM state type for the AHB input hold stage.
package ahb_input_hold_stage_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TRANS_W  = 2;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 3;
    localparam int unsigned PROT_W   = 4;
    localparam int unsigned MASTER_W = 4;

    localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [TRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [BURST_W-1:0] HBURST_SINGLE = 3'b000;
    localparam logic [BURST_W-1:0] HBURST_INCR   = 3'b001;
    localparam logic [BURST_W-1:0] HBURST_WRAP4  = 3'b010;
    localparam logic [BURST_W-1:0] HBURST_INCR4  = 3'b011;
    localparam logic [BURST_W-1:0] HBURST_WRAP8  = 3'b100;
    localparam logic [BURST_W-1:0] HBURST_INCR8  = 3'b101;
    localparam logic [BURST_W-1:0] HBURST_WRAP16 = 3'b110;
    localparam logic [BURST_W-1:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    // Fixed-length bursts (WRAPx/INCRx) cannot survive an arbitration break.
    function automatic logic is_fixed_burst(input logic [BURST_W-1:0] burst);
        return (burst != HBURST_SINGLE) && (burst != HBURST_INCR);
    endfunction

endpackage

// File: rtl/ahb_input_hold_stage.sv
// AHB matrix input stage: passes address phases straight through or holds them until granted.
// Optional macro AHB_HOLD_ERR_CANCEL_EN cancels transfers presented during a two-cycle ERROR.
module ahb_input_hold_stage
    import ahb_input_hold_stage_pkg::*;
(
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSELS,
    input  logic [ADDR_W-1:0]   HADDRS,
    input  logic [TRANS_W-1:0]  HTRANSS,
    input  logic                HWRITES,
    input  logic [SIZE_W-1:0]   HSIZES,
    input  logic [BURST_W-1:0]  HBURSTS,
    input  logic [PROT_W-1:0]   HPROTS,
    input  logic [MASTER_W-1:0] HMASTERS,
    input  logic                HMASTLOCKS,
    input  logic                HREADYS,
    output logic                HREADYOUTS,
    output logic                HRESPS,
    input  logic                active_ip,
    input  logic                readyout_ip,
    input  logic                resp_ip,
    output logic                sel_ip,
    output logic [ADDR_W-1:0]   addr_ip,
    output logic [TRANS_W-1:0]  trans_ip,
    output logic                write_ip,
    output logic [SIZE_W-1:0]   size_ip,
    output logic [BURST_W-1:0]  burst_ip,
    output logic [PROT_W-1:0]   prot_ip,
    output logic [MASTER_W-1:0] master_ip,
    output logic                mastlock_ip,
    output logic                held_tran_ip
);

    state_t                r_state;
    logic                  r_sel;
    logic [ADDR_W-1:0]     r_addr;
    logic [TRANS_W-1:0]    r_trans;
    logic                  r_write;
    logic [SIZE_W-1:0]     r_size;
    logic [BURST_W-1:0]    r_burst;
    logic [PROT_W-1:0]     r_prot;
    logic [MASTER_W-1:0]   r_master;
    logic                  r_mastlock;

    logic w_valid;
    logic w_cancel;
    logic w_accept;
    logic w_held;

    assign w_valid = HSELS & HTRANSS[1] & HREADYS;
    assign w_held  = (r_state == ST_HELD);

`ifdef AHB_HOLD_ERR_CANCEL_EN
    // Both ERROR cycles of a data phase suppress any newly presented transfer.
    assign w_cancel = (r_state == ST_DATA) & resp_ip;
`else
    assign w_cancel = 1'b0;
`endif

    // A held transfer blocks new captures until it has been granted.
    assign w_accept = w_valid & ~w_cancel & ~w_held;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= active_ip ? ST_DATA : ST_HELD;
                ST_HELD: if (active_ip & readyout_ip) r_state <= ST_DATA;
                ST_DATA: begin
                    if (w_accept)         r_state <= active_ip ? ST_DATA : ST_HELD;
                    else if (readyout_ip) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Hold registers track the master whenever its address phase is sampled.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sel      <= 1'b0;
            r_addr     <= '0;
            r_trans    <= '0;
            r_write    <= 1'b0;
            r_size     <= '0;
            r_burst    <= '0;
            r_prot     <= '0;
            r_master   <= '0;
            r_mastlock <= 1'b0;
        end else if (HREADYS & ~w_held) begin
            r_sel      <= HSELS;
            r_addr     <= HADDRS;
            r_trans    <= HTRANSS;
            r_write    <= HWRITES;
            r_size     <= HSIZES;
            r_burst    <= HBURSTS;
            r_prot     <= HPROTS;
            r_master   <= HMASTERS;
            r_mastlock <= HMASTLOCKS;
        end
    end

    always_comb begin
        sel_ip      = HSELS;
        addr_ip     = HADDRS;
        trans_ip    = HTRANSS;
        write_ip    = HWRITES;
        size_ip     = HSIZES;
        burst_ip    = HBURSTS;
        prot_ip     = HPROTS;
        master_ip   = HMASTERS;
        mastlock_ip = HMASTLOCKS;
        if (w_held) begin
            sel_ip      = r_sel;
            addr_ip     = r_addr;
            trans_ip    = (r_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : r_trans;
            write_ip    = r_write;
            size_ip     = r_size;
            burst_ip    = is_fixed_burst(r_burst) ? HBURST_INCR : r_burst;
            prot_ip     = r_prot;
            master_ip   = r_master;
            mastlock_ip = r_mastlock;
        end
        if (HRESET | w_cancel) begin
            trans_ip = HTRANS_IDLE;
        end
    end

    always_comb begin
        held_tran_ip = ~HRESET & (w_held | w_accept);
        HRESPS       = (r_state == ST_DATA) & resp_ip;
        HREADYOUTS   = 1'b1;
        case (r_state)
            ST_HELD: HREADYOUTS = 1'b0;
            ST_DATA: HREADYOUTS = readyout_ip;
            default: HREADYOUTS = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ahb_input_hold_stage.sv
// Directed self-checking bench for ahb_input_hold_stage; honours AHB_HOLD_ERR_CANCEL_EN.
module tb_ahb_input_hold_stage;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        active_ip;
    logic        readyout_ip;
    logic        resp_ip;
    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_ip;
    logic        mastlock_ip;
    logic        held_tran_ip;

    int checks = 0;
    int errors = 0;

`ifdef AHB_HOLD_ERR_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    always #5 HCLK = ~HCLK;

    ahb_input_hold_stage dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip), .write_ip(write_ip),
        .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip), .master_ip(master_ip),
        .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip)
    );

    // Quiet master and a ready, OKAY, ungranted output stage.
    task automatic drive_idle();
        HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTERS = '0; HMASTLOCKS = 1'b0;
        HREADYS = 1'b1; active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        HRESET = 1'b0;
        #2 HRESET = 1'b1;
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h1234_5678; resp_ip = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b exp 1", HREADYOUTS); end
        checks++; if (HRESPS !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b exp 0", HRESPS); end
        checks++; if (held_tran_ip !== 1'b0) begin errors++; $display("FAIL reset_held: got %b exp 0", held_tran_ip); end
        checks++; if (trans_ip !== 2'b00) begin errors++; $display("FAIL reset_trans: got %b exp 00", trans_ip); end
        checks++; if (addr_ip !== 32'h1234_5678) begin errors++; $display("FAIL reset_addr: got %h exp 12345678", addr_ip); end
        next_cycle();
        HRESET = 1'b0;
        drive_idle();
    endtask

    task automatic test_pass_through();
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = 32'h2000_0000;
        HSIZES = 3'b010; active_ip = 1'b1;
        @(negedge HCLK);
        checks++; if (addr_ip !== 32'h2000_0000) begin errors++; $display("FAIL pt_addr: got %h exp 20000000", addr_ip); end
        checks++; if (write_ip !== 1'b1) begin errors++; $display("FAIL pt_write: got %b exp 1", write_ip); end
        checks++; if (trans_ip !== 2'b10) begin errors++; $display("FAIL pt_trans: got %b exp 10", trans_ip); end
        checks++; if (held_tran_ip !== 1'b1) begin errors++; $display("FAIL pt_held: got %b exp 1", held_tran_ip); end
        next_cycle();
        drive_idle(); readyout_ip = 1'b0; HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL pt_data_wait: got %b exp 0", HREADYOUTS); end
        next_cycle();
        drive_idle();
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL pt_data_done: got %b exp 1", HREADYOUTS); end
        next_cycle();
        drive_idle(); readyout_ip = 1'b0; HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL pt_back_idle: got %b exp 1", HREADYOUTS); end
    endtask

    task automatic test_held();
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h4000_0010; HSIZES = 3'b010;
        HPROTS = 4'b0011; HMASTERS = 4'd5;
        @(negedge HCLK);
        checks++; if (held_tran_ip !== 1'b1) begin errors++; $display("FAIL held_present: got %b exp 1", held_tran_ip); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_idle(); HADDRS = 32'hDEAD_BEEF; HWRITES = 1'b1; HREADYS = 1'b0;
            @(negedge HCLK);
            checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL held_hready[%0d]: got %b exp 0", i, HREADYOUTS); end
            checks++; if (addr_ip !== 32'h4000_0010) begin errors++; $display("FAIL held_addr[%0d]: got %h exp 40000010", i, addr_ip); end
            checks++; if (held_tran_ip !== 1'b1) begin errors++; $display("FAIL held_flag[%0d]: got %b exp 1", i, held_tran_ip); end
        end
        checks++; if (write_ip !== 1'b0 || master_ip !== 4'd5 || prot_ip !== 4'b0011 || sel_ip !== 1'b1)
            begin errors++; $display("FAIL held_ctrl: got w=%b m=%0d p=%b s=%b exp w=0 m=5 p=0011 s=1", write_ip, master_ip, prot_ip, sel_ip); end
        next_cycle();
        drive_idle(); HADDRS = 32'hDEAD_BEEF; HREADYS = 1'b0; active_ip = 1'b1;
        @(negedge HCLK);
        checks++; if (addr_ip !== 32'h4000_0010 || trans_ip !== 2'b10) begin errors++; $display("FAIL held_grant: got %h/%b exp 40000010/10", addr_ip, trans_ip); end
        next_cycle();
        drive_idle(); HADDRS = 32'hDEAD_BEEF; HREADYS = 1'b0; readyout_ip = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL held_to_data: got %b exp 0", HREADYOUTS); end
        checks++; if (addr_ip !== 32'hDEAD_BEEF || held_tran_ip !== 1'b0) begin errors++; $display("FAIL held_release: got %h/%b exp deadbeef/0", addr_ip, held_tran_ip); end
        next_cycle();
        drive_idle();
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL held_done: got %b exp 1", HREADYOUTS); end
    endtask

    task automatic test_burst_break();
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HBURSTS = 3'b011; HADDRS = 32'h0000_1000; active_ip = 1'b1;
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b11; HBURSTS = 3'b011; HADDRS = 32'h0000_1004;
        @(negedge HCLK);
        checks++; if (trans_ip !== 2'b11 || burst_ip !== 3'b011) begin errors++; $display("FAIL burst_pass: got %b/%b exp 11/011", trans_ip, burst_ip); end
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b11; HBURSTS = 3'b011; HADDRS = 32'h0000_1008; HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (trans_ip !== 2'b10) begin errors++; $display("FAIL burst_trans: got %b exp 10", trans_ip); end
        checks++; if (burst_ip !== 3'b001) begin errors++; $display("FAIL burst_incr: got %b exp 001", burst_ip); end
        checks++; if (addr_ip !== 32'h0000_1004 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL burst_hold: got %h/%b exp 00001004/0", addr_ip, HREADYOUTS); end
        active_ip = 1'b1;
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b01; HBURSTS = 3'b011; HADDRS = 32'h0000_1008;
        HREADYS = 1'b0; readyout_ip = 1'b0;
        @(negedge HCLK);
        checks++; if (trans_ip !== 2'b01 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b/%b exp 01/0", trans_ip, HREADYOUTS); end
        next_cycle();
        drive_idle();
        next_cycle();
        drive_idle(); HSELS = 1'b1; HTRANSS = 2'b01;
        @(negedge HCLK);
        checks++; if (held_tran_ip !== 1'b0) begin errors++; $display("FAIL busy_idle_held: got %b exp 0", held_tran_ip); end
        next_cycle();
        drive_idle(); readyout_ip = 1'b0; HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL busy_stays_idle: got %b exp 1", HREADYOUTS); end
    endtask

    task automatic test_error();
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_3000; active_ip = 1'b1;
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_5000; active_ip = 1'b1;
        resp_ip = 1'b1; readyout_ip = 1'b0;
        @(negedge HCLK);
        checks++; if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL err1_resp: got %b/%b exp 1/0", HRESPS, HREADYOUTS); end
        checks++; if (trans_ip !== (CANCEL ? 2'b00 : 2'b10)) begin errors++; $display("FAIL err1_trans: got %b exp %b", trans_ip, CANCEL ? 2'b00 : 2'b10); end
        checks++; if (held_tran_ip !== !CANCEL) begin errors++; $display("FAIL err1_held: got %b exp %b", held_tran_ip, !CANCEL); end
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_5000; active_ip = 1'b1; resp_ip = 1'b1;
        @(negedge HCLK);
        checks++; if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL err2_resp: got %b/%b exp 1/1", HRESPS, HREADYOUTS); end
        checks++; if (trans_ip !== (CANCEL ? 2'b00 : 2'b10)) begin errors++; $display("FAIL err2_trans: got %b exp %b", trans_ip, CANCEL ? 2'b00 : 2'b10); end
        next_cycle();
        drive_idle(); readyout_ip = 1'b0; HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== CANCEL) begin errors++; $display("FAIL err_after: got %b exp %b", HREADYOUTS, CANCEL); end
        checks++; if (HRESPS !== 1'b0) begin errors++; $display("FAIL err_after_resp: got %b exp 0", HRESPS); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_held();
        next_cycle();
        drive_idle();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_6000;
        next_cycle();
        drive_idle(); HREADYS = 1'b0;
        @(negedge HCLK);
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL rh_in_held: got %b exp 0", HREADYOUTS); end
        #1 HRESET = 1'b1;
        #1;
        checks++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin errors++; $display("FAIL rh_immediate: got %b/%b exp 1/0", HREADYOUTS, held_tran_ip); end
        next_cycle();
        HRESET = 1'b0;
        drive_idle(); active_ip = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checks++; if (held_tran_ip !== 1'b0 || trans_ip !== 2'b00 || HREADYOUTS !== 1'b1)
                begin errors++; $display("FAIL rh_after[%0d]: got held=%b trans=%b rdy=%b exp 0/00/1", i, held_tran_ip, trans_ip, HREADYOUTS); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_held();
        test_burst_break();
        test_error();
        test_reset_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
